// File: rtl/panel_scanner_pkg.sv
// Shared constants, state encoding and helpers for the HUB75 panel scanner.
// Optional macro PANEL_SCANNER_GAMMA_EN selects the gamma-corrected pixel path timing.
package panel_scanner_pkg;

   localparam int PANEL_W   = 64;
   localparam int PANEL_H   = 32;
   localparam int SCAN_ROWS = 16;
   localparam int PLANES    = 8;

   localparam int COL_W   = 6;
   localparam int ROW_W   = 5;
   localparam int SCAN_W  = 4;
   localparam int PLANE_W = 3;
   localparam int ADDR_W  = ROW_W + COL_W;
   localparam int PH_W    = 3;

   localparam logic [1:0] ST_SHIFT   = 2'd0;
   localparam logic [1:0] ST_LATCH   = 2'd1;
   localparam logic [1:0] ST_DISPLAY = 2'd2;
   localparam logic [1:0] ST_NEXT    = 2'd3;

   // Colour is presented on PH_DRIVE and clocked into the panel on PH_CLK.
`ifdef PANEL_SCANNER_GAMMA_EN
   localparam logic [PH_W-1:0] PH_DRIVE = 3'd3;
`else
   localparam logic [PH_W-1:0] PH_DRIVE = 3'd2;
`endif
   localparam logic [PH_W-1:0] PH_CAP = PH_DRIVE - 3'd1;
   localparam logic [PH_W-1:0] PH_CLK = PH_DRIVE + 3'd1;

   // {r, g, b} bit of one bit-plane from a {blue, green, red} pixel.
   function automatic logic [2:0] plane_bits(input logic [23:0] px, input logic [PLANE_W-1:0] p);
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
      red   = px[7:0];
      green = px[15:8];
      blue  = px[23:16];
      return {red[p], green[p], blue[p]};
   endfunction

   // Gamma 2.0 curve, rounded to nearest.
   function automatic logic [7:0] gamma_value(input int x);
      int v;
      v = (x * x + 127) / 255;
      return v[7:0];
   endfunction

endpackage

// File: rtl/panel_gamma_lut.sv
// 256-entry gamma ROM with registered output; one instance per colour channel.
// Only instantiated when PANEL_SCANNER_GAMMA_EN is defined.
module panel_gamma_lut
   import panel_scanner_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   output logic [7:0] dout
);

   logic [7:0] rom [256];

   for (genvar i = 0; i < 256; i++) begin : g_rom
      assign rom[i] = gamma_value(i);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dout <= '0;
      else      dout <= rom[din];
   end

endmodule

// File: rtl/panel_scanner.sv
// HUB75 64x32 1/16-scan driver with bit-plane (BCM) brightness and double-buffered frames.
// Define PANEL_SCANNER_GAMMA_EN to insert a registered gamma table (one extra clk per column).
module panel_scanner
   import panel_scanner_pkg::*;
#(
   parameter int BCM_BASE = 8
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_buf,
   input  logic [23:0]       rd_data,
   input  logic              selected_buffer,
   output logic              actual_buffer,
   output logic              r1,
   output logic              g1,
   output logic              b1,
   output logic              r2,
   output logic              g2,
   output logic              b2,
   output logic [SCAN_W-1:0] row_sel,
   output logic              sclk,
   output logic              lat,
   output logic              oe_n,
   output logic [1:0]        dbg_state
);

   logic [1:0]         state;
   logic [PH_W-1:0]    phase;
   logic [COL_W-1:0]   col;
   logic [SCAN_W-1:0]  row;
   logic [PLANE_W-1:0] plane;
   logic [31:0]        disp_cnt;
   logic [31:0]        disp_len;
   logic [23:0]        pix_src;
   logic [2:0]         upper_q;
   logic [2:0]         lower_bits;
   logic [5:0]         color_q;
   logic [5:0]         color_out;
   logic               drive_now;
   logic               frame_end;

   // Read contract: rd_data returns the pixel at rd_addr exactly one clk later, no stalls.
`ifdef PANEL_SCANNER_GAMMA_EN
   logic [7:0] gam_r;
   logic [7:0] gam_g;
   logic [7:0] gam_b;

   panel_gamma_lut u_gamma_r (.clk(clk), .rst(rst), .din(rd_data[7:0]),   .dout(gam_r));
   panel_gamma_lut u_gamma_g (.clk(clk), .rst(rst), .din(rd_data[15:8]),  .dout(gam_g));
   panel_gamma_lut u_gamma_b (.clk(clk), .rst(rst), .din(rd_data[23:16]), .dout(gam_b));

   assign pix_src = {gam_b, gam_g, gam_r};
`else
   assign pix_src = rd_data;
`endif

   assign lower_bits = plane_bits(pix_src, plane);
   assign disp_len   = 32'(BCM_BASE) << plane;
   assign frame_end  = (row == SCAN_W'(SCAN_ROWS - 1)) && (plane == PLANE_W'(PLANES - 1));
   assign drive_now  = (state == ST_SHIFT) && (phase == PH_DRIVE);

   // Lower pixel arrives during the drive phase, so it is forwarded straight to the
   // pins for that clk and held from color_q afterwards; sclk is still low then.
   assign color_out = drive_now ? {upper_q, lower_bits} : color_q;
   assign {r1, g1, b1, r2, g2, b2} = color_out;

   assign rd_addr   = ((state == ST_SHIFT) && (phase == 3'd1)) ? {1'b1, row, col} : {1'b0, row, col};
   assign sclk      = (state == ST_SHIFT) && (phase == PH_CLK);
   assign lat       = (state == ST_LATCH);
   assign oe_n      = (state != ST_DISPLAY);
   assign rd_buf    = actual_buffer;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_SHIFT;
         phase         <= '0;
         col           <= '0;
         row           <= '0;
         plane         <= '0;
         disp_cnt      <= '0;
         row_sel       <= '0;
         actual_buffer <= 1'b0;
         upper_q       <= '0;
         color_q       <= '0;
      end else begin
         case (state)
            ST_SHIFT: begin
               if (phase == PH_CAP)   upper_q <= lower_bits;
               if (phase == PH_DRIVE) color_q <= {upper_q, lower_bits};
               if (phase == PH_CLK) begin
                  phase <= '0;
                  col   <= col + 6'd1;
                  if (col == COL_W'(PANEL_W - 1)) begin
                     state   <= ST_LATCH;
                     row_sel <= row;
                  end
               end else begin
                  phase <= phase + 3'd1;
               end
            end
            ST_LATCH: begin
               state    <= ST_DISPLAY;
               disp_cnt <= '0;
            end
            ST_DISPLAY: begin
               if (disp_cnt == disp_len - 32'd1) state <= ST_NEXT;
               else                              disp_cnt <= disp_cnt + 32'd1;
            end
            default: begin
               plane <= plane + 3'd1;
               col   <= '0;
               if (plane == PLANE_W'(PLANES - 1)) row <= row + 4'd1;
               // Buffer swaps only here so a frame is never shown torn.
               if (frame_end && (selected_buffer != actual_buffer)) actual_buffer <= selected_buffer;
               state <= ST_SHIFT;
            end
         endcase
      end
   end

endmodule

// File: doc/panel_scanner.md
PANEL_SCANNER -- requirements
Module: panel_scanner

Interface
REQ-001 Parameter BCM_BASE, default 8, sets the clk cycles oe_n is held low for bit-plane 0; plane p is held low for BCM_BASE<<p cycles.
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 rd_addr  output  11  frame-buffer read address {row[4:0], col[5:0]}.
REQ-005 rd_buf  output  1  buffer half being read; always equal to actual_buffer.
REQ-006 rd_data  input  24  {blue, green, red}, 8 bits each; valid exactly 1 clk after rd_addr.
REQ-007 selected_buffer  input  1  buffer requested for display by the frame-buffer writer.
REQ-008 actual_buffer  output  1  buffer currently displayed; the writer fills the other half.
REQ-009 r1, g1, b1, r2, g2, b2  output  1 each  HUB75 colour bits, upper half (rows 0-15) and lower half (rows 16-31).
REQ-010 row_sel  output  4  HUB75 row address A-D.
REQ-011 sclk, lat, oe_n  output  1 each  HUB75 shift clock, latch, active-low output enable.

Function
REQ-012 Panel is 64 columns x 32 rows at 1/16 scan; a frame is 16 row-pairs x 8 bit-planes, scanned plane 0..7 within a row, then rows 0..15.
REQ-013 States: SHIFT, LATCH, DISPLAY, NEXT; the machine leaves reset in SHIFT with row 0, plane 0, col 0.
REQ-014 SHIFT, per column c, 4 clks: T0 rd_addr={row,c}; T1 rd_addr={row+16,c}, capture upper pixel; T2 capture lower pixel and drive r1..b2 from bit[plane] of each channel, sclk=0; T3 sclk=1.
REQ-015 sclk is low in every state other than SHIFT-T3; colour outputs change only while sclk is low.
REQ-016 After column 63 T3, go to LATCH: lat=1 for exactly 1 clk, oe_n=1; row_sel is updated to the current row in the same clk.
REQ-017 DISPLAY: oe_n=0 for exactly BCM_BASE<<plane clks, then oe_n=1 and go to NEXT.
REQ-018 NEXT (1 clk): plane increments; when plane wraps 7->0, row increments; column resets to 0; then go to SHIFT.
REQ-019 Frame end is NEXT with row 15 and plane 7: if selected_buffer != actual_buffer, actual_buffer <= selected_buffer in that clk; otherwise unchanged.
REQ-020 actual_buffer and rd_buf change at no time other than frame end; a toggle of selected_buffer mid-frame is not honoured before the frame end.
REQ-021 A selected_buffer that toggles twice within one frame (net unchanged) causes no swap.
REQ-022 row_sel never changes while oe_n=0.
REQ-023 Row counter wraps 15->0 and plane counter wraps 7->0 with no extra states.

Reset
REQ-024 While rst=0: oe_n=1, lat=0, sclk=0, r1..b2=0, row_sel=0, rd_addr=0, actual_buffer=0, rd_buf=0, all counters 0.
REQ-025 Reset asserted mid-operation takes effect immediately (asynchronous); on release, scanning restarts at row 0, plane 0, col 0 in SHIFT-T0.

Configuration
REQ-026 With macro PANEL_SCANNER_GAMMA_EN defined, each 8-bit channel passes through a registered gamma table before bit selection, adding 1 clk: SHIFT takes 5 clks/column and colour is driven on T3, sclk=1 on T4.
REQ-027 Without PANEL_SCANNER_GAMMA_EN, channels are used linearly and the REQ-014 4-clk timing holds.

Structure
REQ-028 Shared package holds: panel width 64, height 32, scan rows 16, plane count 8, address field widths, state encoding.
REQ-029 Gamma table is sub-module panel_gamma_lut (8-bit in, 8-bit registered out, 256-entry ROM), instantiated only under PANEL_SCANNER_GAMMA_EN.

Verification
REQ-030 Reset release, rd_data=0xFFFFFF constant -> 64 sclk rising edges, then 1 lat pulse, then oe_n low 8 clks (plane 0); r1..b2=1 on every shift.
REQ-031 rd_data model returns red=0x05 -> r1 high on planes 0 and 2 only; oe_n low widths 8,16,32,...,1024 clks for planes 0..7.
REQ-032 Memory model of rd_addr -> upper pixel {row,c} and lower pixel {row+16,c} for all 16 rows, 64 columns; row_sel steps 0..15 and wraps to 0.
REQ-033 selected_buffer toggled to 1 mid-frame -> actual_buffer stays 0 until the frame-end NEXT clk, then 1; rd_buf follows.
REQ-034 rst pulsed low during DISPLAY of row 7 -> oe_n=1 immediately, all outputs at reset values; scanning restarts at row 0, plane 0.
REQ-035 PANEL_SCANNER_GAMMA_EN defined -> 5 clks between sclk rising edges; output bits match gamma-table values.
